// File: rtl/multi_queue_read_arbiter.sv
// multi_queue_read_arbiter: credit-gated round-robin read grant across FIFO queues
// clk, rst: clock and synchronous active-high reset
// q_valid, q_ready: per-queue head valid in, onehot0 read grant out (same cycle)
// credit_return, credit_avail: per-queue slot-freed pulse in, credit-nonzero flag out
// grant_idx, grant_any: granted queue index (0 when idle) and any-grant flag
// credit_overflow: sticky, credit returned to a queue already holding CREDITS
// MULTI_QUEUE_READ_ARBITER_STATS_EN adds grant_count, per-queue saturating 16-bit grant totals
module multi_queue_read_arbiter #(
  parameter int QUEUE_COUNT = 2,
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [QUEUE_COUNT-1:0] q_valid,
  output logic [QUEUE_COUNT-1:0] q_ready,
  input  logic [QUEUE_COUNT-1:0] credit_return,
  output logic [QUEUE_COUNT-1:0] credit_avail,
  output logic [$clog2(QUEUE_COUNT)-1:0] grant_idx,
  output logic grant_any,
  output logic credit_overflow
`ifdef MULTI_QUEUE_READ_ARBITER_STATS_EN
  ,
  output logic [QUEUE_COUNT-1:0][15:0] grant_count
`endif
);
  localparam int IW = $clog2(QUEUE_COUNT);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  logic [IW-1:0] ptr;
  logic [IW-1:0] j;
  logic [CW-1:0] credit [QUEUE_COUNT];
  logic [QUEUE_COUNT-1:0] elig;
  // Scan from ptr+N-1 down to ptr so the last hit is the first eligible queue after ptr.
  always_comb begin
    j = '0;
    for (int i = 0; i < QUEUE_COUNT; i++) begin
      credit_avail[i] = credit[i] != '0;
      elig[i] = q_valid[i] && credit_avail[i] && !rst;
    end
    grant_any = |elig;
    grant_idx = '0;
    for (int k = QUEUE_COUNT - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % QUEUE_COUNT);
      grant_idx = elig[j] ? j : grant_idx;
    end
    q_ready = grant_any ? QUEUE_COUNT'(1) << grant_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      credit_overflow <= 1'b0;
      for (int i = 0; i < QUEUE_COUNT; i++) credit[i] <= FULL;
    end else begin
      if (grant_any) ptr <= (grant_idx == IW'(QUEUE_COUNT - 1)) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < QUEUE_COUNT; i++) begin
        if (q_ready[i] && !credit_return[i]) credit[i] <= credit[i] - 1'b1;
        else if (credit_return[i] && !q_ready[i]) begin
          if (credit[i] == FULL) credit_overflow <= 1'b1;
          else credit[i] <= credit[i] + 1'b1;
        end
      end
    end
  end
`ifdef MULTI_QUEUE_READ_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_COUNT; i++) begin
      if (rst) grant_count[i] <= '0;
      else if (q_ready[i] && grant_count[i] != 16'hffff) grant_count[i] <= grant_count[i] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_multi_queue_read_arbiter.sv
// tb_multi_queue_read_arbiter: directed and random checks against a round-robin credit model
module tb_multi_queue_read_arbiter;
  localparam int N = 2;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] q_valid = '0;
  logic [N-1:0] credit_return = '0;
  logic [N-1:0] q_ready;
  logic [N-1:0] credit_avail;
  logic [$clog2(N)-1:0] grant_idx;
  logic grant_any;
  logic credit_overflow;
  int vectors = 0;
  int miscompares = 0;
  int cred [N];
  int ptr = 0;
  bit ovf = 1'b0;
  int exp_g = -1;

  multi_queue_read_arbiter #(.QUEUE_COUNT(N), .CREDITS(C)) dut (
    .clk(clk),
    .rst(rst),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .credit_return(credit_return),
    .credit_avail(credit_avail),
    .grant_idx(grant_idx),
    .grant_any(grant_any),
    .credit_overflow(credit_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] qv, input logic [N-1:0] cr);
    rst = r;
    q_valid = qv;
    credit_return = cr;
    #3;
    exp_g = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        int q;
        q = (ptr + k) % N;
        if (qv[q] && cred[q] > 0) begin
          exp_g = q;
          break;
        end
      end
    end
    chk("q_ready", int'(q_ready), exp_g < 0 ? 0 : 1 << exp_g);
    chk("grant_idx", int'(grant_idx), exp_g < 0 ? 0 : exp_g);
    chk("grant_any", int'(grant_any), int'(exp_g >= 0));
    for (int i = 0; i < N; i++) chk("credit_avail", int'(credit_avail[i]), int'(cred[i] > 0));
    chk("credit_overflow", int'(credit_overflow), int'(ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ptr = 0;
      ovf = 1'b0;
      for (int i = 0; i < N; i++) cred[i] = C;
    end else begin
      if (exp_g >= 0) ptr = (exp_g + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (exp_g == i && !credit_return[i]) cred[i]--;
        else if (exp_g != i && credit_return[i]) begin
          if (cred[i] == C) ovf = 1'b1;
          else cred[i]++;
        end
      end
    end
    #1;
  endtask

  initial begin
    tick();
    cyc(1'b1, 2'b11, 2'b11);
    chk("rst_q_ready", int'(q_ready), 0);
    chk("rst_grant_any", int'(grant_any), 0);
    chk("rst_grant_idx", int'(grant_idx), 0);
    tick();
    for (int n = 0; n < 2; n++) begin
      cyc(1'b0, 2'b11, 2'b01);
      chk("alt_q0", int'(q_ready), 1);
      if (n == 0) begin
        chk("post_rst_avail", int'(credit_avail), 3);
        chk("post_rst_ovf", int'(credit_overflow), 0);
      end
      tick();
      cyc(1'b0, 2'b11, 2'b10);
      chk("alt_q1", int'(q_ready), 2);
      tick();
    end
    cyc(1'b1, 2'b00, 2'b00);
    tick();
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 2'b01, 2'b00);
      chk("drain_grant", int'(q_ready), 1);
      tick();
    end
    cyc(1'b0, 2'b01, 2'b00);
    chk("drained_no_grant", int'(q_ready), 0);
    chk("drained_avail0", int'(credit_avail[0]), 0);
    tick();
    cyc(1'b0, 2'b01, 2'b01);
    chk("zero_credit_no_grant", int'(q_ready), 0);
    tick();
    cyc(1'b0, 2'b01, 2'b00);
    chk("returned_grant", int'(q_ready), 1);
    tick();
    cyc(1'b0, 2'b01, 2'b00);
    chk("back_to_zero", int'(credit_avail[0]), 0);
    tick();
    cyc(1'b1, 2'b00, 2'b00);
    tick();
    repeat (2) begin
      cyc(1'b0, 2'b01, 2'b00);
      tick();
    end
    cyc(1'b0, 2'b01, 2'b01);
    chk("simul_grant", int'(q_ready), 1);
    tick();
    repeat (2) begin
      cyc(1'b0, 2'b00, 2'b01);
      tick();
    end
    cyc(1'b0, 2'b00, 2'b00);
    chk("full_no_ovf", int'(credit_overflow), 0);
    tick();
    cyc(1'b0, 2'b00, 2'b01);
    tick();
    cyc(1'b0, 2'b00, 2'b00);
    chk("ovf_set", int'(credit_overflow), 1);
    tick();
    cyc(1'b0, 2'b11, 2'b00);
    chk("ovf_sticky", int'(credit_overflow), 1);
    tick();
    cyc(1'b1, 2'b00, 2'b00);
    tick();
    cyc(1'b0, 2'b00, 2'b00);
    chk("ovf_cleared", int'(credit_overflow), 0);
    tick();
    repeat (6) begin
      cyc(1'b0, 2'b11, 2'b00);
      tick();
    end
    cyc(1'b0, 2'b00, 2'b00);
    chk("at_one_avail", int'(credit_avail), 3);
    tick();
    cyc(1'b1, 2'b11, 2'b11);
    chk("mid_rst_no_grant", int'(q_ready), 0);
    tick();
    cyc(1'b0, 2'b11, 2'b00);
    chk("after_rst_ptr0", int'(q_ready), 1);
    tick();
    for (int n = 0; n < 7; n++) begin
      cyc(1'b0, 2'b11, 2'b00);
      chk("refilled_grant", int'(grant_any), 1);
      tick();
    end
    cyc(1'b0, 2'b11, 2'b00);
    chk("refilled_exhausted", int'(grant_any), 0);
    tick();
    repeat (3000) begin
      cyc($urandom_range(0, 49) == 0, N'($urandom), $urandom_range(0, 2) == 0 ? N'($urandom) : '0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
